// File: rtl/commit_trace_transmitter_if.sv
// -----------------------------------------------------------------------------
// commit_trace_transmitter_if
//
// Word-serial valid/ready link carrying commit trace records from the
// hardware-side transmitter to the host-side trace reader.
//
// Signals:
//   txValid  producer -> consumer  txData holds a valid word
//   txData   producer -> consumer  current 32-bit word
//   txLast   producer -> consumer  current word is the last of its record
//   txReady  consumer -> producer  consumer accepts the word this cycle
//
// Modports:
//   master  transmitter side (drives txValid/txData/txLast)
//   slave   reader side (drives txReady)
// -----------------------------------------------------------------------------
interface commit_trace_transmitter_if;
  logic        txValid;
  logic [31:0] txData;
  logic        txLast;
  logic        txReady;

  modport master (output txValid, output txData, output txLast, input txReady);
  modport slave  (input txValid, input txData, input txLast, output txReady);
endinterface

// File: rtl/commit_trace_transmitter.sv
// -----------------------------------------------------------------------------
// commit_trace_transmitter
//
// Observes up to COMMIT_WIDTH committed ops per cycle, buffers one record per
// op in a FIFO and serializes each record as 32-bit words on a valid/ready
// link. It never back-pressures the commit stage: ops that do not fit are
// dropped and counted in a saturating 16-bit counter.
//
// Record layout:
//   word 0  {4'hC, writeReg, logDst, phyDst, sid zero-extended to 15 bits}
//   word 1  PC zero-extended to 32 bits
//   word 2  enqueue-cycle timestamp (only with RSD_COMMIT_TRACE_TIMESTAMP_EN)
// The header packing fills exactly 32 bits when LREG_WIDTH + PREG_WIDTH = 12.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   cmValid      per-slot commit strobe
//   cmSid        per-slot op serial
//   cmPc         per-slot PC
//   cmWriteReg   per-slot "writes a destination register"
//   cmLogDst     per-slot logical destination
//   cmPhyDst     per-slot physical destination
//   tx           trace word link (master side)
//   dropCount    records dropped since reset, saturating at 16'hFFFF
//
// Configuration macro:
//   RSD_COMMIT_TRACE_TIMESTAMP_EN  adds a free-running 32-bit cycle counter
//                                  and a third word per record.
// -----------------------------------------------------------------------------
module commit_trace_transmitter #(
  parameter int COMMIT_WIDTH = 2,
  parameter int FIFO_DEPTH   = 16,
  parameter int SID_WIDTH    = 10,
  parameter int LREG_WIDTH   = 5,
  parameter int PREG_WIDTH   = 7,
  parameter int PC_WIDTH     = 32
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [COMMIT_WIDTH-1:0]                 cmValid,
  input  logic [COMMIT_WIDTH-1:0][SID_WIDTH-1:0]  cmSid,
  input  logic [COMMIT_WIDTH-1:0][PC_WIDTH-1:0]   cmPc,
  input  logic [COMMIT_WIDTH-1:0]                 cmWriteReg,
  input  logic [COMMIT_WIDTH-1:0][LREG_WIDTH-1:0] cmLogDst,
  input  logic [COMMIT_WIDTH-1:0][PREG_WIDTH-1:0] cmPhyDst,
  commit_trace_transmitter_if.master              tx,
  output logic [15:0]                             dropCount
);

`ifdef RSD_COMMIT_TRACE_TIMESTAMP_EN
  localparam int N_WORDS = 3;
`else
  localparam int N_WORDS = 2;
`endif
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SLOT_W = $clog2(COMMIT_WIDTH + 1);
  // One width for occupancy and slot arithmetic so comparisons are exact.
  localparam int ACC_W  = (CNT_W > SLOT_W) ? CNT_W : SLOT_W;

  // Record storage, one array per word position.
  logic [31:0] hdr_mem [FIFO_DEPTH];
  logic [31:0] pc_mem  [FIFO_DEPTH];
`ifdef RSD_COMMIT_TRACE_TIMESTAMP_EN
  logic [31:0] ts_mem  [FIFO_DEPTH];
  logic [31:0] ts_reg;
`endif

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [ACC_W-1:0] count_reg;
  logic [1:0]       w_idx_reg;
  logic [15:0]      drop_count_reg;

  logic [COMMIT_WIDTH-1:0][ACC_W-1:0] slot_rank;
  logic [COMMIT_WIDTH-1:0]            slot_wen;
  logic [COMMIT_WIDTH-1:0][PTR_W-1:0] slot_addr;
  logic [COMMIT_WIDTH-1:0][31:0]      slot_hdr;
  logic [COMMIT_WIDTH-1:0][31:0]      slot_pc;

  logic [ACC_W-1:0] valid_total;
  logic [ACC_W-1:0] free_space;
  logic [ACC_W-1:0] push_count;
  logic [ACC_W-1:0] drop_slots;
  logic [16:0]      drop_sum;
  logic             tx_fire;
  logic             pop;
  logic [31:0]      tx_word;

  // Free space uses the start-of-cycle count: a same-cycle pop does not
  // make room for this cycle's commits.
  assign free_space = ACC_W'(FIFO_DEPTH) - count_reg;

  // Rank of each valid slot among the valid slots (compaction order).
  always_comb begin : p_rank
    logic [ACC_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      slot_rank[i] = acc;
      acc = acc + ACC_W'(cmValid[i]);
    end
    valid_total = acc;
  end

  assign push_count = (valid_total > free_space) ? free_space : valid_total;
  assign drop_slots = valid_total - push_count;
  assign drop_sum   = {1'b0, drop_count_reg} + 17'(drop_slots);

  genvar gi;
  generate
    for (gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_slot
      // Lowest-ranked valid slots win the available entries.
      assign slot_wen[gi]  = cmValid[gi] && (slot_rank[gi] < free_space);
      assign slot_addr[gi] = wr_ptr_reg + PTR_W'(slot_rank[gi]);
      assign slot_hdr[gi]  = 32'({4'hC, cmWriteReg[gi], cmLogDst[gi],
                                  cmPhyDst[gi], 15'(cmSid[gi])});
      assign slot_pc[gi]   = 32'(cmPc[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (slot_wen[i]) begin
        hdr_mem[slot_addr[i]] <= slot_hdr[i];
        pc_mem[slot_addr[i]]  <= slot_pc[i];
`ifdef RSD_COMMIT_TRACE_TIMESTAMP_EN
        ts_mem[slot_addr[i]]  <= ts_reg;
`endif
      end
    end
  end

  assign tx_fire = tx.txValid && tx.txReady;
  assign pop     = tx_fire && tx.txLast;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      w_idx_reg      <= '0;
      drop_count_reg <= '0;
`ifdef RSD_COMMIT_TRACE_TIMESTAMP_EN
      ts_reg         <= '0;
`endif
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PTR_W'(push_count);
      count_reg  <= count_reg + push_count - ACC_W'(pop);
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (tx_fire) begin
        w_idx_reg <= tx.txLast ? 2'd0 : w_idx_reg + 2'd1;
      end
      drop_count_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
`ifdef RSD_COMMIT_TRACE_TIMESTAMP_EN
      ts_reg <= ts_reg + 32'd1;
`endif
    end
  end

  // Word select from the head entry; forced to zero while empty so the
  // link shows a clean idle value.
  always_comb begin
    tx_word = '0;
    if (tx.txValid) begin
      case (w_idx_reg)
        2'd0:    tx_word = hdr_mem[rd_ptr_reg];
        2'd1:    tx_word = pc_mem[rd_ptr_reg];
`ifdef RSD_COMMIT_TRACE_TIMESTAMP_EN
        2'd2:    tx_word = ts_mem[rd_ptr_reg];
`endif
        default: tx_word = '0;
      endcase
    end
  end

  assign tx.txValid = (count_reg != '0);
  assign tx.txLast  = (w_idx_reg == 2'(N_WORDS - 1));
  assign tx.txData  = tx_word;
  assign dropCount  = drop_count_reg;

endmodule

// File: tb/tb_commit_trace_transmitter.sv
// -----------------------------------------------------------------------------
// tb_commit_trace_transmitter
//
// Self-checking bench for commit_trace_transmitter (FIFO_DEPTH = 4).
// A record-level reference model (queue of expected words) runs alongside
// every cycle; directed table vectors, hand-written multi-cycle sequences and
// randomized traffic are all checked against it and against constants.
// -----------------------------------------------------------------------------
module tb_commit_trace_transmitter;
  localparam int CW    = 2;
  localparam int DEPTH = 4;
  localparam int SIDW  = 10;
  localparam int LW    = 5;
  localparam int PW    = 7;
  localparam int PCW   = 32;
`ifdef RSD_COMMIT_TRACE_TIMESTAMP_EN
  localparam int NW = 3;
`else
  localparam int NW = 2;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [CW-1:0]           cm_valid;
  logic [CW-1:0][SIDW-1:0] cm_sid;
  logic [CW-1:0][PCW-1:0]  cm_pc;
  logic [CW-1:0]           cm_write_reg;
  logic [CW-1:0][LW-1:0]   cm_log_dst;
  logic [CW-1:0][PW-1:0]   cm_phy_dst;
  logic [15:0]             drop_count;

  commit_trace_transmitter_if tx_if ();

  commit_trace_transmitter #(
    .COMMIT_WIDTH(CW), .FIFO_DEPTH(DEPTH), .SID_WIDTH(SIDW),
    .LREG_WIDTH(LW), .PREG_WIDTH(PW), .PC_WIDTH(PCW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmValid   (cm_valid),
    .cmSid     (cm_sid),
    .cmPc      (cm_pc),
    .cmWriteReg(cm_write_reg),
    .cmLogDst  (cm_log_dst),
    .cmPhyDst  (cm_phy_dst),
    .tx        (tx_if),
    .dropCount (drop_count)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] data;
    logic        last;
  } word_t;

  word_t       wq[$];
  int          rec_cnt;
  int          drop_m;
  logic [31:0] ts_m;

  function automatic logic [31:0] mk_hdr(input logic wr, input logic [4:0] ld,
                                         input logic [6:0] pd, input logic [9:0] sid);
    return 32'hC000_0000 | ({31'd0, wr} << 27) | ({27'd0, ld} << 22)
         | ({25'd0, pd} << 15) | {22'd0, sid};
  endfunction

  // Models the effect of the coming clock edge given the current inputs.
  task automatic model_update();
    int    free;
    word_t w;
    if (rst) begin
      wq.delete();
      rec_cnt = 0;
      drop_m  = 0;
      ts_m    = '0;
      return;
    end
    free = DEPTH - rec_cnt;
    if (wq.size() > 0 && tx_if.txReady) begin
      w = wq.pop_front();
      $display("tx word %08h last=%0d", w.data, w.last);
      if (w.last) rec_cnt--;
    end
    for (int i = 0; i < CW; i++) begin
      if (cm_valid[i]) begin
        if (free > 0) begin
          wq.push_back('{mk_hdr(cm_write_reg[i], cm_log_dst[i], cm_phy_dst[i], cm_sid[i]), 1'b0});
          wq.push_back('{cm_pc[i], (NW == 2)});
          if (NW == 3) wq.push_back('{ts_m, 1'b1});
          rec_cnt++;
          free--;
        end else if (drop_m < 65535) begin
          drop_m++;
        end
      end
    end
    ts_m = ts_m + 32'd1;
  endtask

  task automatic check_model();
    logic        ev;
    logic [31:0] ed;
    logic        el;
    ev = (wq.size() > 0);
    ed = ev ? wq[0].data : 32'd0;
    el = ev ? wq[0].last : 1'b0;
    chk("model_txValid", {31'd0, tx_if.txValid}, {31'd0, ev});
    chk("model_txData", tx_if.txData, ed);
    chk("model_txLast", {31'd0, tx_if.txLast}, {31'd0, el});
    chk("model_dropCount", {16'd0, drop_count}, 32'(drop_m));
  endtask

  // Inputs are set while clk is low; outputs are checked on the falling edge.
  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle_inputs();
    cm_valid = '0; cm_sid = '0; cm_pc = '0;
    cm_write_reg = '0; cm_log_dst = '0; cm_phy_dst = '0;
  endtask

  task automatic set_slot(input int i, input logic [9:0] sid, input logic [31:0] pc,
                          input logic wr, input logic [4:0] ld, input logic [6:0] pd);
    cm_valid[i] = 1'b1; cm_sid[i] = sid; cm_pc[i] = pc;
    cm_write_reg[i] = wr; cm_log_dst[i] = ld; cm_phy_dst[i] = pd;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  valid;
    logic [9:0]  sid0, sid1;
    logic [31:0] pc0, pc1;
    logic        wr;
    logic [4:0]  ld;
    logic [6:0]  pd;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_last;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{2'b01, 10'd5,    10'd0, 32'h1000,     32'h0,    1'b1, 5'd3,  7'd40,  1'b1, 1'b1, 32'hC8D4_0005, 1'b0};
    vecs[1]  = '{2'b00, 10'd0,    10'd0, 32'h0,        32'h0,    1'b0, 5'd0,  7'd0,   1'b1, 1'b1, 32'h0000_1000, 1'b1};
    vecs[2]  = '{2'b00, 10'd0,    10'd0, 32'h0,        32'h0,    1'b0, 5'd0,  7'd0,   1'b1, 1'b0, 32'h0,         1'b0};
    vecs[3]  = '{2'b01, 10'd5,    10'd0, 32'h1000,     32'h0,    1'b0, 5'd3,  7'd40,  1'b1, 1'b1, 32'hC0D4_0005, 1'b0};
    vecs[4]  = '{2'b00, 10'd0,    10'd0, 32'h0,        32'h0,    1'b0, 5'd0,  7'd0,   1'b1, 1'b1, 32'h0000_1000, 1'b1};
    vecs[5]  = '{2'b00, 10'd0,    10'd0, 32'h0,        32'h0,    1'b0, 5'd0,  7'd0,   1'b1, 1'b0, 32'h0,         1'b0};
    vecs[6]  = '{2'b11, 10'd7,    10'd8, 32'h2000,     32'h2004, 1'b0, 5'd0,  7'd0,   1'b1, 1'b1, 32'hC000_0007, 1'b0};
    vecs[7]  = '{2'b00, 10'd0,    10'd0, 32'h0,        32'h0,    1'b0, 5'd0,  7'd0,   1'b1, 1'b1, 32'h0000_2000, 1'b1};
    vecs[8]  = '{2'b00, 10'd0,    10'd0, 32'h0,        32'h0,    1'b0, 5'd0,  7'd0,   1'b1, 1'b1, 32'hC000_0008, 1'b0};
    vecs[9]  = '{2'b00, 10'd0,    10'd0, 32'h0,        32'h0,    1'b0, 5'd0,  7'd0,   1'b1, 1'b1, 32'h0000_2004, 1'b1};
    vecs[10] = '{2'b00, 10'd0,    10'd0, 32'h0,        32'h0,    1'b0, 5'd0,  7'd0,   1'b1, 1'b0, 32'h0,         1'b0};
    vecs[11] = '{2'b10, 10'd0,  10'd1023, 32'h0,   32'hFFFF_FFFC, 1'b1, 5'd31, 7'd127, 1'b1, 1'b1, 32'hCFFF_83FF, 1'b0};
    vecs[12] = '{2'b00, 10'd0,    10'd0, 32'h0,        32'h0,    1'b0, 5'd0,  7'd0,   1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1};
    vecs[13] = '{2'b00, 10'd0,    10'd0, 32'h0,        32'h0,    1'b0, 5'd0,  7'd0,   1'b1, 1'b0, 32'h0,         1'b0};
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    tx_if.txReady = 1'b0;
    idle_inputs();
    rec_cnt = 0; drop_m = 0; ts_m = '0;

    // Reset state
    tick();
    chk("reset_txValid", {31'd0, tx_if.txValid}, 32'd0);
    chk("reset_txLast", {31'd0, tx_if.txLast}, 32'd0);
    chk("reset_txData", tx_if.txData, 32'd0);
    chk("reset_dropCount", {16'd0, drop_count}, 32'd0);
    rst = 1'b0;

`ifdef RSD_COMMIT_TRACE_TIMESTAMP_EN
    // Commit captured 10 cycles after reset carries timestamp 10.
    for (int i = 0; i < 10; i++) tick();
    set_slot(0, 10'd3, 32'h500, 1'b0, 5'd0, 7'd0);
    tx_if.txReady = 1'b1;
    tick();
    idle_inputs();
    tick();
    tick();
    chk("ts_word2", tx_if.txData, 32'd10);
    chk("ts_last", {31'd0, tx_if.txLast}, 32'd1);
    tick();
`else
    // Table-driven vectors (two-word records)
    for (int r = 0; r < 14; r++) begin
      cm_valid = vecs[r].valid;
      cm_sid[0] = vecs[r].sid0;       cm_sid[1] = vecs[r].sid1;
      cm_pc[0]  = vecs[r].pc0;        cm_pc[1]  = vecs[r].pc1;
      cm_write_reg = {2{vecs[r].wr}};
      cm_log_dst[0] = vecs[r].ld;     cm_log_dst[1] = vecs[r].ld;
      cm_phy_dst[0] = vecs[r].pd;     cm_phy_dst[1] = vecs[r].pd;
      tx_if.txReady = vecs[r].ready;
      tick();
      chk($sformatf("vec%0d_txValid", r), {31'd0, tx_if.txValid}, {31'd0, vecs[r].exp_valid});
      chk($sformatf("vec%0d_txData", r), tx_if.txData, vecs[r].exp_data);
      chk($sformatf("vec%0d_txLast", r), {31'd0, tx_if.txLast}, {31'd0, vecs[r].exp_last});
    end
    idle_inputs();
`endif

    // Backpressure mid-record
    set_slot(0, 10'd9, 32'h3000, 1'b1, 5'd1, 7'd2);
    tx_if.txReady = 1'b1;
    tick();
    chk("bp_hdr", tx_if.txData, 32'hC841_0009);
    idle_inputs();
    tick();
    tx_if.txReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", {31'd0, tx_if.txValid}, 32'd1);
      chk("bp_hold_data", tx_if.txData, 32'h3000);
      chk("bp_hold_last", {31'd0, tx_if.txLast}, {31'd0, (NW == 2)});
    end
    tx_if.txReady = 1'b1;
    for (int i = 0; i < NW - 1; i++) tick();
    chk("bp_done", {31'd0, tx_if.txValid}, 32'd0);

    // Overflow: 6 commits into 4 entries with the link stalled
    tx_if.txReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idle_inputs();
      set_slot(0, 10'(2 * k + 1), 32'((2 * k + 1) * 4), 1'b0, 5'd0, 7'd0);
      set_slot(1, 10'(2 * k + 2), 32'((2 * k + 2) * 4), 1'b0, 5'd0, 7'd0);
      tick();
    end
    idle_inputs();
    chk("ovf_drop", {16'd0, drop_count}, 32'd2);
    tx_if.txReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < NW; w++) begin
        if (w == 0) chk($sformatf("ovf_order%0d", k), tx_if.txData, 32'hC000_0000 | 32'(k + 1));
        tick();
      end
    end
    chk("ovf_empty", {31'd0, tx_if.txValid}, 32'd0);

    // Full FIFO with a pop in the same cycle still drops the commit
    tx_if.txReady = 1'b0;
    for (int k = 0; k < 2; k++) begin
      idle_inputs();
      set_slot(0, 10'(21 + 2 * k), 32'((21 + 2 * k) * 4), 1'b0, 5'd0, 7'd0);
      set_slot(1, 10'(22 + 2 * k), 32'((22 + 2 * k) * 4), 1'b0, 5'd0, 7'd0);
      tick();
    end
    idle_inputs();
    tx_if.txReady = 1'b1;
    for (int i = 0; i < NW - 1; i++) tick();
    set_slot(0, 10'd25, 32'h64, 1'b0, 5'd0, 7'd0);
    tick();
    idle_inputs();
    chk("full_pop_drop", {16'd0, drop_count}, 32'd3);
    chk("full_pop_next", tx_if.txData, 32'hC000_0016);

    // Reset after the header of a record has been accepted
    tick();
    chk("rst_pre_word1", tx_if.txData, 32'h58);
    rst = 1'b1;
    tick();
    chk("rst_mid_txValid", {31'd0, tx_if.txValid}, 32'd0);
    chk("rst_mid_drop", {16'd0, drop_count}, 32'd0);
    chk("rst_mid_txLast", {31'd0, tx_if.txLast}, 32'd0);
    rst = 1'b0;
    tx_if.txReady = 1'b0;
    set_slot(0, 10'd11, 32'h4000, 1'b0, 5'd0, 7'd0);
    tick();
    idle_inputs();
    chk("rst_restart_hdr", tx_if.txData, 32'hC000_000B);
    chk("rst_restart_last", {31'd0, tx_if.txLast}, 32'd0);
    tx_if.txReady = 1'b1;
    for (int i = 0; i < NW; i++) tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < CW; i++) begin
        cm_valid[i]     = 1'($urandom_range(0, 1));
        cm_sid[i]       = 10'($urandom);
        cm_pc[i]        = $urandom;
        cm_write_reg[i] = 1'($urandom);
        cm_log_dst[i]   = 5'($urandom);
        cm_phy_dst[i]   = 7'($urandom);
      end
      tx_if.txReady = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0;

    // Drop counter saturation
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    tx_if.txReady = 1'b0;
    cm_valid = 2'b11;
    for (int c = 0; c < 32769; c++) tick();
    chk("sat_below", {16'd0, drop_count}, 32'h0000_FFFE);
    tick();
    chk("sat_reach", {16'd0, drop_count}, 32'h0000_FFFF);
    tick();
    chk("sat_hold", {16'd0, drop_count}, 32'h0000_FFFF);
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
